// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the producers, the round-robin write arbiter and the FIFO write side.
// Carries err_cnt only when FIFO_ARB_ERR_CNT_EN is defined.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            ack;
  logic                          err;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;
`ifdef FIFO_ARB_ERR_CNT_EN
  logic [7:0]                    err_cnt;

  modport master (
    input  req, req_last, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    output gnt, ack, err, fifo_wr_en, fifo_data_in, err_cnt
  );
  modport slave (
    output req, req_last, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    input  gnt, ack, err, fifo_wr_en, fifo_data_in, err_cnt
  );
`else
  modport master (
    input  req, req_last, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    output gnt, ack, err, fifo_wr_en, fifo_data_in
  );
  modport slave (
    output req, req_last, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    input  gnt, ack, err, fifo_wr_en, fifo_data_in
  );
`endif
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a synchronous FIFO, with packet lock and
// wr_ack routing. Optional saturating fault counter enabled by FIFO_ARB_ERR_CNT_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   sel;
  logic               found;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] gnt_q;
  int                 idx;

  function automatic logic [PTR_W-1:0] inc_wrap(input logic [PTR_W-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    return p + 1'b1;
  endfunction

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    sel      = '0;
    found    = 1'b0;
    idx      = 0;
    gnt      = '0;

    // No grant at all while in reset or while the FIFO reports full.
    if (rst_n && !bus.fifo_full) begin
      if (state_q == IDLE) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = int'(rr_ptr_q) + k;
          if (idx >= NUM_REQ) idx = idx - NUM_REQ;
          if (!found && bus.req[idx]) begin
            found = 1'b1;
            sel   = PTR_W'(idx);
          end
        end
      end else begin
        sel   = owner_q;
        found = bus.req[owner_q];
      end
    end

    if (found) begin
      gnt[sel] = 1'b1;
      if (state_q == IDLE) begin
        if (bus.req_last[sel]) begin
          rr_ptr_d = inc_wrap(sel);
        end else begin
          state_d = LOCK;
          owner_d = sel;
        end
      end else if (bus.req_last[sel]) begin
        state_d  = IDLE;
        rr_ptr_d = inc_wrap(owner_q);
      end
    end
  end

  always_comb begin
    bus.fifo_data_in = '0;
    if (found) bus.fifo_data_in = bus.req_data[int'(sel)*FIFO_WIDTH +: FIFO_WIDTH];
  end

  assign bus.gnt        = gnt;
  assign bus.fifo_wr_en = |gnt;

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt;
    end
  end

  // The FIFO's wr_ack/overflow are already registered and line up with gnt_q, so the
  // response is one cycle after the grant without a further flop stage.
  assign bus.ack = (rst_n && bus.fifo_wr_ack) ? gnt_q : '0;
  assign bus.err = rst_n && (((|gnt_q) != bus.fifo_wr_ack) || bus.fifo_overflow);

`ifdef FIFO_ARB_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                           err_cnt_q <= '0;
    else if (bus.err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter driving an 8-deep FIFO flag model.
// Counter checks are compiled in when FIFO_ARB_ERR_CNT_EN is defined.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int W  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .FIFO_WIDTH(W)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // FIFO flag model: depth 8, write accepted when not full, nack/spurious overrides.
  int   count;
  logic wr_ack_q, ovf_q;
  logic rd_en, force_nack, spur_ack, spur_ovf;

  assign bus.fifo_full     = (count == 8);
  assign bus.fifo_wr_ack   = wr_ack_q | spur_ack;
  assign bus.fifo_overflow = ovf_q | spur_ovf;

  always @(posedge clk) begin
    if (!rst_n) begin
      count    <= 0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ack_q <= bus.fifo_wr_en && !bus.fifo_full && !force_nack;
      ovf_q    <= bus.fifo_wr_en && bus.fifo_full;
      count    <= count + ((bus.fifo_wr_en && !bus.fifo_full && !force_nack) ? 1 : 0)
                        - ((rd_en && count > 0) ? 1 : 0);
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One cycle: sample combinational outputs at the falling edge, then advance.
  task automatic cyc(input string tag, input logic [3:0] eg, input logic [15:0] ed,
                     input logic [3:0] ea, input logic ee);
    @(negedge clk);
    check({tag, ".gnt"},   32'(bus.gnt),          32'(eg));
    check({tag, ".wr_en"}, 32'(bus.fifo_wr_en),   32'(|eg));
    check({tag, ".data"},  32'(bus.fifo_data_in), 32'(ed));
    check({tag, ".ack"},   32'(bus.ack),          32'(ea));
    check({tag, ".err"},   32'(bus.err),          32'(ee));
    tick();
  endtask

  task automatic set_data(input int i, input logic [15:0] v);
    bus.req_data[i*W +: W] = v;
  endtask

  task automatic drain;
    bus.req = '0;
    rd_en   = 1'b1;
    repeat (10) tick();
    rd_en   = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    rd_en      = 1'b0;
    force_nack = 1'b0;
    spur_ack   = 1'b0;
    spur_ovf   = 1'b0;
    bus.req      = 4'b1111;
    bus.req_last = 4'b1111;
    for (int i = 0; i < NR; i++) set_data(i, 16'hA000 + 16'(i));

    // Reset holds every output low even with all requests up.
    cyc("rst", 4'b0000, 16'h0000, 4'b0000, 1'b0);
`ifdef FIFO_ARB_ERR_CNT_EN
    check("rst.err_cnt", 32'(bus.err_cnt), 32'd0);
`endif
    tick();
    rst_n = 1'b1;

    // Round robin over single-beat packets fills the 8-deep FIFO.
    for (int k = 0; k < 8; k++)
      cyc("rr", 4'(1 << (k % 4)), 16'hA000 + 16'(k % 4),
          (k == 0) ? 4'b0000 : 4'(1 << ((k - 1) % 4)), 1'b0);
    cyc("full", 4'b0000, 16'h0000, 4'b1000, 1'b0);

    // One read per slot frees exactly one grant, continuing from the stored pointer.
    for (int j = 0; j < 3; j++) begin
      rd_en = 1'b1;
      cyc("rd", 4'b0000, 16'h0000, (j == 0) ? 4'b0000 : 4'(1 << (j - 1)), 1'b0);
      rd_en = 1'b0;
      cyc("refill", 4'(1 << j), 16'hA000 + 16'(j), 4'b0000, 1'b0);
    end
    drain();

    // Three-beat packet from requester 2 while 0 and 1 wait; pointer at 3.
    bus.req = 4'b0100; bus.req_last = 4'b0000; set_data(2, 16'hB000);
    cyc("lock_a", 4'b0100, 16'hB000, 4'b0000, 1'b0);
    bus.req = 4'b0111; set_data(2, 16'hB001);
    cyc("lock_b", 4'b0100, 16'hB001, 4'b0100, 1'b0);
    bus.req_last = 4'b0100; set_data(2, 16'hB002);
    cyc("lock_c", 4'b0100, 16'hB002, 4'b0100, 1'b0);
    bus.req = 4'b0011; bus.req_last = 4'b0011; set_data(2, 16'hA002);
    cyc("unlock_wrap", 4'b0001, 16'hA000, 4'b0100, 1'b0);
    bus.req = 4'b0010;
    cyc("after_lock", 4'b0010, 16'hA001, 4'b0001, 1'b0);
    bus.req = 4'b0000;
    cyc("idle", 4'b0000, 16'h0000, 4'b0010, 1'b0);
    drain();

    // Owner drops req mid-packet: nobody else gets through.
    bus.req = 4'b1000; bus.req_last = 4'b0000; set_data(3, 16'hC000);
    cyc("own_a", 4'b1000, 16'hC000, 4'b0000, 1'b0);
    bus.req = 4'b0011; bus.req_last = 4'b0011;
    cyc("own_gap", 4'b0000, 16'h0000, 4'b1000, 1'b0);
    bus.req = 4'b1011; bus.req_last = 4'b1011; set_data(3, 16'hC001);
    cyc("own_last", 4'b1000, 16'hC001, 4'b0000, 1'b0);
    bus.req = 4'b0011;
    cyc("post_own", 4'b0001, 16'hA000, 4'b1000, 1'b0);
    bus.req = 4'b0000;
    cyc("quiet", 4'b0000, 16'h0000, 4'b0001, 1'b0);
    set_data(3, 16'hA003);

    // Spurious FIFO responses with no grant outstanding.
    spur_ack = 1'b1;
    cyc("spur_ack", 4'b0000, 16'h0000, 4'b0000, 1'b1);
`ifdef FIFO_ARB_ERR_CNT_EN
    check("cnt_1", 32'(bus.err_cnt), 32'd1);
`endif
    spur_ack = 1'b0; spur_ovf = 1'b1;
    cyc("spur_ovf", 4'b0000, 16'h0000, 4'b0000, 1'b1);
`ifdef FIFO_ARB_ERR_CNT_EN
    check("cnt_2", 32'(bus.err_cnt), 32'd2);
`endif
    spur_ovf = 1'b0;
    cyc("no_fault", 4'b0000, 16'h0000, 4'b0000, 1'b0);

    // Missing wr_ack after a grant.
    force_nack = 1'b1;
    bus.req = 4'b0001; bus.req_last = 4'b0001;
    cyc("nack_gnt", 4'b0001, 16'hA000, 4'b0000, 1'b0);
    bus.req = 4'b0000;
    cyc("nack_err", 4'b0000, 16'h0000, 4'b0000, 1'b1);
`ifdef FIFO_ARB_ERR_CNT_EN
    check("cnt_3", 32'(bus.err_cnt), 32'd3);
`endif
    cyc("nack_clr", 4'b0000, 16'h0000, 4'b0000, 1'b0);
`ifdef FIFO_ARB_ERR_CNT_EN
    bus.req = 4'b0001;
    repeat (300) tick();
    bus.req = 4'b0000;
    repeat (2) tick();
    check("cnt_sat", 32'(bus.err_cnt), 32'd255);
`endif
    force_nack = 1'b0;

    // Reset in the middle of a packet locked on requester 1.
    bus.req = 4'b0010; bus.req_last = 4'b0000;
    cyc("lock1", 4'b0010, 16'hA001, 4'b0000, 1'b0);
    rst_n = 1'b0; bus.req = 4'b1111; bus.req_last = 4'b1111;
    cyc("mid_rst", 4'b0000, 16'h0000, 4'b0000, 1'b0);
`ifdef FIFO_ARB_ERR_CNT_EN
    check("cnt_rst", 32'(bus.err_cnt), 32'd0);
`endif
    rst_n = 1'b1; bus.req = 4'b1100; bus.req_last = 4'b1100;
    cyc("post_rst", 4'b0100, 16'hA002, 4'b0000, 1'b0);
    bus.req = 4'b1000;
    cyc("post_rst2", 4'b1000, 16'hA003, 4'b0100, 1'b0);
    bus.req = 4'b0000;
    cyc("end", 4'b0000, 16'h0000, 4'b1000, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
